ula_sequencial: RTL and testbench

//  Parametrised, registered ALU; successor to the combinational 8-bit ULA.

---
 rtl/ula_sequencial.sv | 161 ++++++++++++++++
 tb/tb_ula_sequencial.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_sequencial.sv
// ula_sequencial: registered ALU with start/ready/done handshake and a registered Z/N/C/V flag set.
// Build macro ULA_MUL_EN: op 111 becomes an iterative shift-add multiplier; otherwise op 111 yields zero in one cycle.
module ula_sequencial #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Inicio,
    input  logic [2:0]       ALUOp,
    input  logic [WIDTH-1:0] Entrada1,
    input  logic [WIDTH-1:0] Entrada2,
    output logic             Livre,
    output logic             Pronto,
    output logic [WIDTH-1:0] Resultado,
    output logic             Zero,
    output logic             Negativo,
    output logic             Carry,
    output logic             Overflow
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_NEG = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;

    // Handshake: an op is accepted on a rising edge where Inicio && Livre; Pronto is high
    // for exactly the cycle after each completion, and Resultado/flags hold until the next one.
    logic               accept_alu;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [2*WIDTH-1:0] shl_w;
    logic               add_v;
    logic               sub_v;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;

    always_comb begin
        add_w   = {1'b0, Entrada1} + {1'b0, Entrada2};
        sub_w   = {1'b0, Entrada1} - {1'b0, Entrada2};
        add_v   = (Entrada1[MSB] == Entrada2[MSB]) && (add_w[MSB] != Entrada1[MSB]);
        sub_v   = (Entrada1[MSB] != Entrada2[MSB]) && (sub_w[MSB] != Entrada1[MSB]);
        // Bit WIDTH of the widened shift is the last bit pushed out (0 when the amount is 0).
        shl_w   = {{WIDTH{1'b0}}, Entrada1} << Entrada2[SHW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUOp)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = add_v;
            end
            OP_NEG: begin
                alu_res = ~Entrada1 + WIDTH'(1);
                alu_v   = (Entrada1 == MIN_VAL);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = sub_v;
            end
            OP_SLT: alu_res = {WIDTH{sub_w[MSB] ^ sub_v}};
            OP_AND: alu_res = Entrada1 & Entrada2;
            OP_OR:  alu_res = Entrada1 | Entrada2;
            OP_SHL: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            default: ;
        endcase
    end

`ifdef ULA_MUL_EN
    localparam logic [2:0]     OP_MUL = 3'b111;
    localparam logic [SHW-1:0] LAST   = SHW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     count;

    assign Livre      = (state == IDLE);
    assign accept_alu = Inicio && Livre && (ALUOp != OP_MUL);
    assign acc_next   = acc + (mplier[0] ? mcand : '0);
`else
    assign Livre      = 1'b1;
    assign accept_alu = Inicio;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            Resultado <= '0;
            Zero      <= 1'b1;
            Negativo  <= 1'b0;
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            Pronto    <= 1'b0;
`ifdef ULA_MUL_EN
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
`endif
        end else begin
            Pronto <= 1'b0;
            if (accept_alu) begin
                Resultado <= alu_res;
                Zero      <= (alu_res == '0);
                Negativo  <= alu_res[MSB];
                Carry     <= alu_c;
                Overflow  <= alu_v;
                Pronto    <= 1'b1;
            end
`ifdef ULA_MUL_EN
            case (state)
                IDLE: begin
                    if (Inicio && (ALUOp == OP_MUL)) begin
                        state  <= MUL;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, Entrada1};
                        mplier <= Entrada2;
                        count  <= '0;
                    end
                end
                MUL: begin
                    // One multiplier bit per cycle; the final cycle commits acc_next directly.
                    acc    <= acc_next;
                    mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    count  <= count + SHW'(1);
                    if (count == LAST) begin
                        state     <= IDLE;
                        Resultado <= acc_next[WIDTH-1:0];
                        Zero      <= (acc_next[WIDTH-1:0] == '0);
                        Negativo  <= acc_next[MSB];
                        Carry     <= |acc_next[2*WIDTH-1:WIDTH];
                        Overflow  <= 1'b0;
                        Pronto    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
`endif
        end
    end
endmodule

// File: tb/tb_ula_sequencial.sv
// tb_ula_sequencial: scoreboard bench for ula_sequencial at WIDTH=8.
// Honours ULA_MUL_EN the same way as the design.
module tb_ula_sequencial;
    localparam int WIDTH = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_NEG = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic             clock = 1'b0;
    logic             reset;
    logic             Inicio;
    logic [2:0]       ALUOp;
    logic [WIDTH-1:0] Entrada1;
    logic [WIDTH-1:0] Entrada2;
    logic             Livre;
    logic             Pronto;
    logic [WIDTH-1:0] Resultado;
    logic             Zero;
    logic             Negativo;
    logic             Carry;
    logic             Overflow;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Entry layout: {Resultado, Zero, Negativo, Carry, Overflow}
    logic [WIDTH+3:0] exp_q[$];
    logic [WIDTH+3:0] mon_exp;
    logic [WIDTH+3:0] mon_got;

    ula_sequencial #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .Inicio    (Inicio),
        .ALUOp     (ALUOp),
        .Entrada1  (Entrada1),
        .Entrada2  (Entrada2),
        .Livre     (Livre),
        .Pronto    (Pronto),
        .Resultado (Resultado),
        .Zero      (Zero),
        .Negativo  (Negativo),
        .Carry     (Carry),
        .Overflow  (Overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", pass_cnt, check_cnt);
        $fatal(1, "timeout");
    end

    function automatic logic [WIDTH+3:0] pack_exp(input logic [7:0] r, input logic c, input logic v);
        return {r, (r == 8'h00), r[7], c, v};
    endfunction

    function automatic logic [WIDTH+3:0] ref_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, s, p, sh;
        logic [7:0] r;
        logic c, v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r = 8'h00;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                s = sa + sb;
                p = int'(a) + int'(b);
                r = 8'(p);
                c = (p > 255);
                v = (s > 127) || (s < -128);
            end
            OP_NEG: begin
                r = 8'(-sa);
                v = (a == 8'h80);
            end
            OP_SUB: begin
                s = sa - sb;
                r = 8'(s);
                c = (a < b);
                v = (s > 127) || (s < -128);
            end
            OP_SLT: r = (sa < sb) ? 8'hFF : 8'h00;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_SHL: begin
                sh = int'(b[2:0]);
                p  = int'(a) * (1 << sh);
                r  = 8'(p);
                c  = (sh != 0) ? a[8-sh] : 1'b0;
            end
            default: begin
`ifdef ULA_MUL_EN
                p = int'(a) * int'(b);
                r = 8'(p);
                c = (p > 255);
`endif
            end
        endcase
        return pack_exp(r, c, v);
    endfunction

    // Scoreboard: every Pronto pulse consumes one expected entry.
    always @(negedge clock) begin
        if (!reset && Pronto === 1'b1) begin
            check_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pronto: Pronto=1 at %0t, required no completion", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_got = {Resultado, Zero, Negativo, Carry, Overflow};
                if (mon_got !== mon_exp)
                    $display("FAIL result: got res=%h znvc=%b required res=%h znvc=%b at %0t",
                             mon_got[11:4], mon_got[3:0], mon_exp[11:4], mon_exp[3:0], $time);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [WIDTH+3:0] e, input string tag);
        Inicio = 1'b1;
        ALUOp = op;
        Entrada1 = a;
        Entrada2 = b;
        exp_q.push_back(e);
        @(posedge clock); #1;
        Inicio = 1'b0;
        @(negedge clock);
        check_cnt++;
        if (Pronto !== 1'b1) $display("FAIL %s_pronto: Pronto=%b required 1", tag, Pronto);
        else pass_cnt++;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Inicio = 1'b0;
        ALUOp = OP_ADD;
        Entrada1 = 8'h00;
        Entrada2 = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_cnt++;
        if (Resultado !== 8'h00) $display("FAIL reset_res: got %h required 00", Resultado);
        else pass_cnt++;
        check_cnt++;
        if ({Zero, Negativo, Carry, Overflow} !== 4'b1000)
            $display("FAIL reset_flags: got %b required 1000", {Zero, Negativo, Carry, Overflow});
        else pass_cnt++;
        check_cnt++;
        if (Pronto !== 1'b0 || Livre !== 1'b1)
            $display("FAIL reset_hs: got Pronto=%b Livre=%b required 0 1", Pronto, Livre);
        else pass_cnt++;
        @(posedge clock); #1;
    endtask

    task automatic test_add();
        do_op(OP_ADD, 8'h7F, 8'h01, pack_exp(8'h80, 1'b0, 1'b1), "add_7f_01");
        @(negedge clock);
        check_cnt++;
        if (Pronto !== 1'b0) $display("FAIL add_pronto_pulse: Pronto=%b required 0", Pronto);
        else pass_cnt++;
        @(posedge clock); #1;
        do_op(OP_ADD, 8'hFF, 8'h01, pack_exp(8'h00, 1'b1, 1'b0), "add_ff_01");
    endtask

    task automatic test_sub_slt_neg();
        do_op(OP_SUB, 8'h03, 8'h05, pack_exp(8'hFE, 1'b1, 1'b0), "sub_03_05");
        do_op(OP_SLT, 8'h80, 8'h01, pack_exp(8'hFF, 1'b0, 1'b0), "slt_80_01");
        do_op(OP_SLT, 8'h7F, 8'h80, pack_exp(8'h00, 1'b0, 1'b0), "slt_7f_80");
        do_op(OP_NEG, 8'h80, 8'h00, pack_exp(8'h80, 1'b0, 1'b1), "neg_80");
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [3];
        logic [7:0] av  [3];
        logic [7:0] bv  [3];
        logic [7:0] rv  [3];
        logic       cv  [3];
        ops = '{OP_AND, OP_OR, OP_SHL};
        av  = '{8'hF0, 8'hF0, 8'h81};
        bv  = '{8'h3C, 8'h3C, 8'h01};
        rv  = '{8'h30, 8'hFC, 8'h02};
        cv  = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            Inicio = 1'b1;
            ALUOp = ops[i];
            Entrada1 = av[i];
            Entrada2 = bv[i];
            exp_q.push_back(pack_exp(rv[i], cv[i], 1'b0));
            @(posedge clock); #1;
            if (i == 2) Inicio = 1'b0;
            @(negedge clock);
            check_cnt++;
            if (Pronto !== 1'b1) $display("FAIL b2b_pronto_%0d: Pronto=%b required 1", i, Pronto);
            else pass_cnt++;
        end
        @(posedge clock); #1;
    endtask

    task automatic test_random();
        logic go;
        logic [2:0] op;
        logic [7:0] a, b;
        for (int i = 0; i < 32; i++) begin
            go = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 6));
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            Inicio = go;
            ALUOp = op;
            Entrada1 = a;
            Entrada2 = b;
            if (go) exp_q.push_back(ref_model(op, a, b));
            @(posedge clock); #1;
        end
        Inicio = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

`ifdef ULA_MUL_EN
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [WIDTH+3:0] e, input string tag);
        bit done;
        int low;
        Inicio = 1'b1;
        ALUOp = OP_MUL;
        Entrada1 = a;
        Entrada2 = b;
        exp_q.push_back(e);
        @(posedge clock); #1;
        Inicio = 1'b0;
        done = 1'b0;
        low = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (Livre === 1'b1) done = 1'b1;
            else low++;
            if (!done) begin
                @(posedge clock); #1;
            end
        end
        check_cnt++;
        if (!done || low != 8 || Pronto !== 1'b1)
            $display("FAIL %s_timing: busy=%0d Pronto=%b required busy=8 Pronto=1", tag, low, Pronto);
        else pass_cnt++;
        @(posedge clock); #1;
    endtask

    task automatic test_mul();
        bit done;
        int low;
        bit early;
        Inicio = 1'b1;
        ALUOp = OP_MUL;
        Entrada1 = 8'h0D;
        Entrada2 = 8'h0B;
        exp_q.push_back(pack_exp(8'h8F, 1'b0, 1'b0));
        @(posedge clock); #1;
        Inicio = 1'b0;
        Entrada1 = 8'hFF;
        Entrada2 = 8'hFF;
        done = 1'b0;
        early = 1'b0;
        low = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clock);
            if (Livre === 1'b1) done = 1'b1;
            else begin
                low++;
                if (Pronto !== 1'b0) early = 1'b1;
            end
            if (!done) begin
                @(posedge clock); #1;
                // Start pulse while busy must be dropped, not queued.
                Inicio = (i == 3);
                ALUOp = OP_ADD;
            end
        end
        Inicio = 1'b0;
        check_cnt++;
        if (!done || low != 8) $display("FAIL mul_livre: busy=%0d required 8", low);
        else pass_cnt++;
        check_cnt++;
        if (Pronto !== 1'b1 || early) $display("FAIL mul_pronto: Pronto=%b early=%b required 1 0", Pronto, early);
        else pass_cnt++;
        @(posedge clock); #1;
        @(negedge clock);
        check_cnt++;
        if (Pronto !== 1'b0) $display("FAIL mul_pronto_pulse: Pronto=%b required 0", Pronto);
        else pass_cnt++;
        @(posedge clock); #1;
        run_mul(8'h10, 8'h10, pack_exp(8'h00, 1'b1, 1'b0), "mul_10_10");
        for (int i = 0; i < 3; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            run_mul(a, b, ref_model(OP_MUL, a, b), "mul_rand");
        end
    endtask

    task automatic test_reset_mid_mul();
        bit seen;
        do_op(OP_ADD, 8'h7F, 8'h01, pack_exp(8'h80, 1'b0, 1'b1), "pre_reset_add");
        Inicio = 1'b1;
        ALUOp = OP_MUL;
        Entrada1 = 8'hFF;
        Entrada2 = 8'hFF;
        @(posedge clock); #1;
        Inicio = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_cnt++;
        if (Resultado !== 8'h00 || Zero !== 1'b1 || Livre !== 1'b1 || Pronto !== 1'b0)
            $display("FAIL mid_mul_reset: res=%h Z=%b Livre=%b Pronto=%b required 00 1 1 0",
                     Resultado, Zero, Livre, Pronto);
        else pass_cnt++;
        @(posedge clock); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clock);
            if (Pronto !== 1'b0) seen = 1'b1;
        end
        check_cnt++;
        if (seen) $display("FAIL mid_mul_abort: Pronto seen=1 required 0");
        else pass_cnt++;
        @(posedge clock); #1;
    endtask
`else
    task automatic test_mul_disabled();
        do_op(OP_MUL, 8'h0D, 8'h0B, pack_exp(8'h00, 1'b0, 1'b0), "mul_off");
        check_cnt++;
        if (Livre !== 1'b1) $display("FAIL mul_off_livre: Livre=%b required 1", Livre);
        else pass_cnt++;
        do_op(OP_ADD, 8'h7F, 8'h01, pack_exp(8'h80, 1'b0, 1'b1), "pre_reset_add");
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_cnt++;
        if (Resultado !== 8'h00 || Zero !== 1'b1 || Pronto !== 1'b0)
            $display("FAIL reset_again: res=%h Z=%b Pronto=%b required 00 1 0", Resultado, Zero, Pronto);
        else pass_cnt++;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub_slt_neg();
        test_back_to_back();
        test_random();
`ifdef ULA_MUL_EN
        test_mul();
        test_reset_mid_mul();
`else
        test_mul_disabled();
`endif
        repeat (2) @(posedge clock);
        check_cnt++;
        if (exp_q.size() != 0) $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
